// File: rtl/layer_4_channel_packer.sv
// Packs a serial, channel-interleaved sample stream into one wide word per pixel.
// Frames IMG_SIZE x IMG_SIZE pixels per start and reports each pixel's row/column.
module layer_4_channel_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned IMG_SIZE   = 104,
  localparam int unsigned OUT_WIDTH = DATA_WIDTH * NUM_CH,
  localparam int unsigned CNT_W     = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  valid_out,
  output logic [CNT_W-1:0]      out_row,
  output logic [CNT_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IMG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CH_W-1:0]        ch_cnt;
  logic [CNT_W-1:0]       row;
  logic [CNT_W-1:0]       col;
  logic [OUT_WIDTH-1:0]   staging;
  logic [OUT_WIDTH-1:0]   pack_c;
  logic                   accept_c;
  logic                   word_end_c;
  logic                   final_c;

  // Acceptance decode and the packed word formed from staging plus the live sample
  always_comb begin
    accept_c   = in_valid & in_ready;
    word_end_c = accept_c && (ch_cnt == LAST_CH);
    final_c    = word_end_c && (row == LAST_POS) && (col == LAST_POS);
    pack_c     = staging;
    pack_c[OUT_WIDTH-DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = RUN;
      RUN:     if (final_c) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ch_cnt    <= '0;
      row       <= '0;
      col       <= '0;
      out_row   <= '0;
      out_col   <= '0;
      staging   <= '0;
      data_out  <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == RUN);
      busy      <= (state_next != IDLE);
      valid_out <= word_end_c;
      done      <= final_c;

      if (state == IDLE && start) begin
        ch_cnt <= '0;
        row    <= '0;
        col    <= '0;
        err    <= 1'b0;
      end

      if (accept_c) begin
        for (int unsigned lane = 0; lane < NUM_CH; lane++) begin
          if (ch_cnt == CH_W'(lane)) staging[lane*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        end
        // in_last must coincide exactly with the final sample of the frame
        if (in_last != final_c) err <= 1'b1;
        if (word_end_c) begin
          ch_cnt   <= '0;
          data_out <= pack_c;
          out_row  <= row;
          out_col  <= col;
          if (col == LAST_POS) begin
            col <= '0;
            row <= (row == LAST_POS) ? '0 : CNT_W'(row + 1'b1);
          end else begin
            col <= CNT_W'(col + 1'b1);
          end
        end else begin
          ch_cnt <= CH_W'(ch_cnt + 1'b1);
        end
      end
    end
  end

endmodule
